branch_target_buffer_assoc: RTL and testbench

- Parametrised, set-associative successor to the direct-mapped BTB. It sits in the fetch stage, beside the direction predictor.
- Lookups are registered: the PC is sampled at a clock edge and the hit, type and target appear the next cycle.
- The update port carries its own branch PC, so no internal address-history pipeline is needed.
- Adds configurable ways, round-robin replacement, optional invalidate on not-taken, and a one-cycle flush.

---
 rtl/branch_target_buffer_assoc.sv | 148 ++++++++++++++
 tb/tb_branch_target_buffer_assoc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer_assoc.sv
// Set-associative branch target buffer with registered lookup, round-robin
// replacement per set, optional invalidate on not-taken, and one-cycle flush.
module branch_target_buffer_assoc #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INDEX_W   = 7,
  parameter int unsigned          TAG_W     = 12,
  parameter int unsigned          WAYS      = 2,
  parameter int unsigned          TYPE_W    = 2,
  parameter logic [TYPE_W-1:0]    TYPE_ABS  = 2'b11,
  parameter bit                   INV_ON_NT = 1'b1,
  localparam int unsigned         WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  output logic              hit,
  output logic [TYPE_W-1:0] pred_type,
  output logic [PC_W-1:0]   pred_tar,
  output logic [WAY_W-1:0]  hit_way,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [TYPE_W-1:0] upd_type,
  input  logic [PC_W-1:0]   upd_tar
);

  localparam int unsigned SETS = 1 << INDEX_W;

  // Valid bits and rr pointers are packed so reset/flush clear them in one go.
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;
  logic [TAG_W-1:0]           tag_q  [SETS][WAYS];
  logic [TYPE_W-1:0]          type_q [SETS][WAYS];
  logic [PC_W-1:0]            tar_q  [SETS][WAYS];

  logic              hit_q;
  logic [TYPE_W-1:0] pred_type_q;
  logic [PC_W-1:0]   pred_tar_q;
  logic [WAY_W-1:0]  hit_way_q;

  logic [INDEX_W-1:0] ridx, uidx;
  logic [TAG_W-1:0]   rtag, utag;

  logic              l_hit;
  logic [WAY_W-1:0]  l_way;
  logic [TYPE_W-1:0] l_type;
  logic [PC_W-1:0]   l_tar;

  logic             u_match, u_has_inv, write_en, inv_en, rr_adv;
  logic [WAY_W-1:0] u_mway, u_iway, victim, rr_nxt;

  logic unused_pc;

  assign ridx = req_pc[INDEX_W+1:2];
  assign rtag = req_pc[INDEX_W+2 +: TAG_W];
  assign uidx = upd_pc[INDEX_W+1:2];
  assign utag = upd_pc[INDEX_W+2 +: TAG_W];
  assign unused_pc = ^{req_pc, upd_pc};

  // Lookup: lowest-numbered valid way with a matching tag in the request set.
  always_comb begin
    l_hit  = 1'b0;
    l_way  = '0;
    l_type = '0;
    l_tar  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!l_hit && valid_q[ridx][w[WAY_W-1:0]] &&
          tag_q[ridx][w[WAY_W-1:0]] == rtag) begin
        l_hit  = 1'b1;
        l_way  = w[WAY_W-1:0];
        l_type = type_q[ridx][w[WAY_W-1:0]];
        l_tar  = tar_q[ridx][w[WAY_W-1:0]];
      end
    end
  end

  // Update: find tag match, first invalid way, pick victim and enables.
  always_comb begin
    u_match   = 1'b0;
    u_mway    = '0;
    u_has_inv = 1'b0;
    u_iway    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!u_match && valid_q[uidx][w[WAY_W-1:0]] &&
          tag_q[uidx][w[WAY_W-1:0]] == utag) begin
        u_match = 1'b1;
        u_mway  = w[WAY_W-1:0];
      end
      if (!u_has_inv && !valid_q[uidx][w[WAY_W-1:0]]) begin
        u_has_inv = 1'b1;
        u_iway    = w[WAY_W-1:0];
      end
    end
    victim   = u_match ? u_mway : (u_has_inv ? u_iway : rr_q[uidx]);
    write_en = upd_valid && !flush && upd_taken && (upd_type != TYPE_ABS);
    inv_en   = upd_valid && !flush && !upd_taken && INV_ON_NT && u_match;
    rr_adv   = write_en && !u_match && !u_has_inv && (WAYS > 1);
    rr_nxt   = (rr_q[uidx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[uidx] + 1'b1;
  end

  // Valid bits and rr pointers: cleared by reset or flush, else update-driven.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      if (write_en) valid_q[uidx][victim] <= 1'b1;
      if (inv_en)   valid_q[uidx][u_mway] <= 1'b0;
      if (rr_adv)   rr_q[uidx]            <= rr_nxt;
    end
  end

  // Entry payload: no reset, written only on an allocating/overwriting update.
  always_ff @(posedge clk) begin
    if (!rst && write_en) begin
      tag_q[uidx][victim]  <= utag;
      type_q[uidx][victim] <= upd_type;
      tar_q[uidx][victim]  <= upd_tar;
    end
  end

  // Lookup output register: holds on stall; flush forces hit low even stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q       <= 1'b0;
      pred_type_q <= '0;
      pred_tar_q  <= '0;
      hit_way_q   <= '0;
    end else begin
      if (!stall) begin
        hit_q       <= req_valid && l_hit;
        pred_type_q <= (req_valid && l_hit) ? l_type : '0;
        pred_tar_q  <= (req_valid && l_hit) ? l_tar  : '0;
        hit_way_q   <= (req_valid && l_hit) ? l_way  : '0;
      end
      if (flush) hit_q <= 1'b0;
    end
  end

  assign hit       = hit_q;
  assign pred_type = pred_type_q;
  assign pred_tar  = pred_tar_q;
  assign hit_way   = hit_way_q;

endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural BTB model.
module tb_branch_target_buffer_assoc;

  logic        clk = 1'b0;
  logic        rst, stall, flush, req_valid, upd_valid, upd_taken;
  logic [31:0] req_pc, upd_pc, upd_tar, pred_tar;
  logic [1:0]  upd_type, pred_type;
  logic        hit;
  logic [0:0]  hit_way;

  int n_chk  = 0;
  int n_fail = 0;

  branch_target_buffer_assoc #(
    .PC_W(32), .INDEX_W(7), .TAG_W(12), .WAYS(2), .TYPE_W(2),
    .TYPE_ABS(2'b11), .INV_ON_NT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_pc(req_pc),
    .hit(hit), .pred_type(pred_type), .pred_tar(pred_tar), .hit_way(hit_way),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_type(upd_type), .upd_tar(upd_tar)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: 128 sets x 2 ways, entries as plain ints.
  bit          mv   [128][2];
  int          mtag [128][2];
  int          mtyp [128][2];
  logic [31:0] mtar [128][2];
  int          mrr  [128];
  logic        e_hit = 1'b0;
  int          e_type = 0, e_way = 0;
  logic [31:0] e_tar = '0;
  int          mi, mt, mf, mfree;

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h7F);
  endfunction
  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 9) & 32'hFFF);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 128; s++) begin mv[s][0] = 0; mv[s][1] = 0; mrr[s] = 0; end
      e_hit = 0; e_type = 0; e_tar = '0; e_way = 0;
    end else begin
      if (!stall) begin
        mi = set_of(req_pc); mt = tag_of(req_pc); mf = -1;
        for (int w = 1; w >= 0; w--) if (mv[mi][w] && mtag[mi][w] == mt) mf = w;
        if (req_valid && mf >= 0) begin
          e_hit = 1; e_type = mtyp[mi][mf]; e_tar = mtar[mi][mf]; e_way = mf;
        end else begin
          e_hit = 0; e_type = 0; e_tar = '0; e_way = 0;
        end
      end
      if (flush) begin
        e_hit = 0;
        for (int s = 0; s < 128; s++) begin mv[s][0] = 0; mv[s][1] = 0; mrr[s] = 0; end
      end else if (upd_valid) begin
        mi = set_of(upd_pc); mt = tag_of(upd_pc); mf = -1; mfree = -1;
        for (int w = 1; w >= 0; w--) begin
          if (mv[mi][w] && mtag[mi][w] == mt) mf = w;
          if (!mv[mi][w]) mfree = w;
        end
        if (upd_taken && upd_type != 2'b11) begin
          if (mf < 0) begin
            if (mfree >= 0) mf = mfree;
            else begin mf = mrr[mi]; mrr[mi] = (mrr[mi] + 1) % 2; end
          end
          mv[mi][mf] = 1; mtag[mi][mf] = mt; mtyp[mi][mf] = int'(upd_type); mtar[mi][mf] = upd_tar;
        end else if (!upd_taken && mf >= 0) begin
          mv[mi][mf] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("m_hit",  {31'b0, hit},       {31'b0, e_hit});
    chk("m_type", {30'b0, pred_type}, e_type);
    chk("m_tar",  pred_tar,           e_tar);
    chk("m_way",  {31'b0, hit_way},   e_way);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; flush = 0; req_valid = 0; req_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_type = '0; upd_tar = '0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [1:0] ty, input logic [31:0] tar);
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_type = ty; upd_tar = tar;
  endtask

  task automatic look(input logic [31:0] pc);
    req_valid = 1; req_pc = pc;
  endtask

  initial begin
    idle(); rst = 1;
    step(); step();
    rst = 0;

    // 1: empty lookup, train, hit
    look(32'h1000); step();
    chk("t1_miss_hit", {31'b0, hit}, 0);
    chk("t1_miss_tar", pred_tar, 0);
    idle(); upd(32'h1000, 1, 2'b01, 32'h2000); step();
    idle(); look(32'h1000); step();
    chk("t1_hit", {31'b0, hit}, 1);
    chk("t1_type", {30'b0, pred_type}, 1);
    chk("t1_tar", pred_tar, 32'h2000);
    chk("t1_way", {31'b0, hit_way}, 0);

    // 2: replacement in set 0 (flush first so set 0 starts empty)
    idle(); flush = 1; step();
    idle(); upd(32'h200, 1, 2'b10, 32'hA001); step();
    idle(); upd(32'h400, 1, 2'b10, 32'hA002); step();
    idle(); upd(32'h600, 1, 2'b10, 32'hA003); step();
    idle(); look(32'h200); step();
    chk("t2_tag1_miss", {31'b0, hit}, 0);
    look(32'h400); step();
    chk("t2_tag2_hit", {31'b0, hit}, 1);
    chk("t2_tag2_way", {31'b0, hit_way}, 1);
    chk("t2_tag2_tar", pred_tar, 32'hA002);
    look(32'h600); step();
    chk("t2_tag3_hit", {31'b0, hit}, 1);
    chk("t2_tag3_way", {31'b0, hit_way}, 0);

    // 3: TYPE_ABS not allocated; not-taken invalidates
    idle(); upd(32'h1000, 1, 2'b11, 32'h7000); step();
    idle(); look(32'h1000); step();
    chk("t3_abs_miss", {31'b0, hit}, 0);
    idle(); upd(32'h600, 0, 2'b10, 32'h0); step();
    idle(); look(32'h600); step();
    chk("t3_nt_miss", {31'b0, hit}, 0);

    // 4: same-edge lookup and update sees old contents
    idle(); look(32'h3000); upd(32'h3000, 1, 2'b01, 32'h4000); step();
    chk("t4_same_edge", {31'b0, hit}, 0);
    idle(); look(32'h3000); step();
    chk("t4_next_hit", {31'b0, hit}, 1);
    chk("t4_next_tar", pred_tar, 32'h4000);

    // 5: stall holds outputs, flush under stall clears hit
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      req_pc = $urandom; req_valid = k[0]; step();
      chk("t5_stall_hit", {31'b0, hit}, 1);
      chk("t5_stall_tar", pred_tar, 32'h4000);
    end
    flush = 1; step();
    chk("t5_flush_hit", {31'b0, hit}, 0);
    idle(); look(32'h3000); step();
    chk("t5_post_miss_a", {31'b0, hit}, 0);
    look(32'h400); step();
    chk("t5_post_miss_b", {31'b0, hit}, 0);

    // 6: flush beats update; reset during stalled lookup
    idle(); flush = 1; upd(32'h5000, 1, 2'b10, 32'h6000); step();
    idle(); look(32'h5000); step();
    chk("t6_flush_upd_miss", {31'b0, hit}, 0);
    idle(); upd(32'h5000, 1, 2'b10, 32'h6000); step();
    idle(); look(32'h5000); step();
    chk("t6_trained_hit", {31'b0, hit}, 1);
    stall = 1; rst = 1; step();
    chk("t6_rst_hit", {31'b0, hit}, 0);
    chk("t6_rst_type", {30'b0, pred_type}, 0);
    chk("t6_rst_tar", pred_tar, 0);
    chk("t6_rst_way", {31'b0, hit_way}, 0);
    rst = 0; idle(); step();

    // Randomized phase over a few sets and tags to force conflicts.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_pc    = ($urandom & 32'hFFE0_0003) | (32'($urandom_range(0, 5)) << 9) |
                  (32'($urandom_range(0, 3)) << 2);
      upd_valid = $urandom_range(0, 1);
      upd_taken = ($urandom_range(0, 9) < 7);
      upd_type  = 2'($urandom_range(0, 3));
      upd_tar   = $urandom;
      upd_pc    = ($urandom & 32'hFFE0_0003) | (32'($urandom_range(0, 5)) << 9) |
                  (32'($urandom_range(0, 3)) << 2);
      step();
    end
    rst = 0; idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
